// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: turns a pressed-key bitmap into per-voice key/gate
// pairs, one assignment per cycle, stealing the least-recently-assigned voice.
module voice_allocator #(
  parameter int N_KEYS   = 32,
  parameter int N_VOICES = 4,
  parameter int KEY_W    = 5
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_KEYS-1:0]         i_keys,
  output logic [N_VOICES*KEY_W-1:0] o_voice_key,
  output logic [N_VOICES-1:0]       o_voice_gate,
  output logic [N_VOICES-1:0]       o_note_on,
  output logic                      o_steal,
  output logic                      o_pending
);

  localparam int VS_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  typedef logic [VS_W-1:0] vidx_t;

  logic [N_KEYS-1:0]   keys_q, dropped, dropped_nx;
  logic [N_KEYS-1:0]   assigned, req, sel_onehot;
  logic [KEY_W-1:0]    vkey [N_VOICES];
  vidx_t               rank [N_VOICES];
  vidx_t               rank_nx [N_VOICES];
  logic [N_VOICES-1:0] rel, free, gate_nx, note_on_nx;
  logic [KEY_W-1:0]    key_sel;
  logic                key_vld, steal_nx, pending_nx;
  vidx_t               voice_sel, oldest;

  always_comb begin
    for (int v = 0; v < N_VOICES; v++) begin
      o_voice_key[v*KEY_W +: KEY_W] = vkey[v];
    end
  end

  // Releases are evaluated before the assignment, so a voice freed this
  // cycle is immediately reusable.
  always_comb begin
    assigned = '0;
    rel      = '0;
    for (int v = 0; v < N_VOICES; v++) begin
      if (o_voice_gate[v]) begin
        assigned[vkey[v]] = 1'b1;
        rel[v]            = ~keys_q[vkey[v]];
      end
    end
    req     = keys_q & ~assigned & ~dropped;
    key_vld = |req;
    key_sel = '0;
    for (int k = N_KEYS - 1; k >= 0; k--) begin
      if (req[k]) key_sel = KEY_W'(k);
    end
    free      = ~(o_voice_gate & ~rel);
    voice_sel = '0;
    oldest    = '0;
    for (int v = N_VOICES - 1; v >= 0; v--) begin
      if (free[v]) voice_sel = vidx_t'(v);
      if (rank[v] == vidx_t'(N_VOICES - 1)) oldest = vidx_t'(v);
    end
    if (~|free) voice_sel = oldest;
  end

  always_comb begin
    gate_nx    = o_voice_gate & ~rel;
    note_on_nx = '0;
    steal_nx   = 1'b0;
    dropped_nx = dropped & keys_q;
    sel_onehot = N_KEYS'(1) << key_sel;
    pending_nx = |(req & ~sel_onehot);
    for (int v = 0; v < N_VOICES; v++) begin
      rank_nx[v] = rank[v];
    end
    if (key_vld) begin
      gate_nx[voice_sel]    = 1'b1;
      note_on_nx[voice_sel] = 1'b1;
      if (~|free) begin
        steal_nx                   = 1'b1;
        dropped_nx[vkey[voice_sel]] = 1'b1;
      end
      for (int v = 0; v < N_VOICES; v++) begin
        if (vidx_t'(v) == voice_sel) rank_nx[v] = '0;
        else if (rank[v] < rank[voice_sel]) rank_nx[v] = vidx_t'(rank[v] + 1'b1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      keys_q       <= '0;
      dropped      <= '0;
      o_voice_gate <= '0;
      o_note_on    <= '0;
      o_steal      <= 1'b0;
      o_pending    <= 1'b0;
      for (int v = 0; v < N_VOICES; v++) begin
        vkey[v] <= '0;
        rank[v] <= vidx_t'(v);
      end
    end else begin
      keys_q       <= i_keys;
      dropped      <= dropped_nx;
      o_voice_gate <= gate_nx;
      o_note_on    <= note_on_nx;
      o_steal      <= steal_nx;
      o_pending    <= pending_nx;
      for (int v = 0; v < N_VOICES; v++) begin
        rank[v] <= rank_nx[v];
      end
      if (key_vld) vkey[voice_sel] <= key_sel;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: vector table, hand-written corner sequences and
// random key traffic checked against a queue-based reference model.
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] keys = '0;
  logic [19:0] voice_key;
  logic [3:0]  voice_gate, note_on;
  logic        steal, pending;

  int n_tests = 0;
  int n_fail  = 0;
  bit model_on = 0;

  voice_allocator #(.N_KEYS(32), .N_VOICES(4), .KEY_W(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_keys(keys),
    .o_voice_key(voice_key), .o_voice_gate(voice_gate),
    .o_note_on(note_on), .o_steal(steal), .o_pending(pending)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_keys_q;
  bit   [31:0] m_dropped;
  int          m_key [4];
  logic [3:0]  m_gate, m_note_on;
  logic        m_steal, m_pending;
  int          lru_q [$];   // front = least recently assigned voice

  task automatic model_reset();
    m_keys_q = '0; m_dropped = '0; m_gate = '0; m_note_on = '0;
    m_steal = 0; m_pending = 0;
    for (int v = 0; v < 4; v++) m_key[v] = 0;
    lru_q = {3, 2, 1, 0};
  endtask

  task automatic model_step(input logic [31:0] in_keys);
    logic [3:0] g_new;
    int req_q [$];
    int v_sel;
    bit held;
    g_new = m_gate;
    for (int v = 0; v < 4; v++)
      if (m_gate[v] && !m_keys_q[m_key[v]]) g_new[v] = 0;
    for (int k = 0; k < 32; k++)
      if (!m_keys_q[k]) m_dropped[k] = 0;
    for (int k = 0; k < 32; k++) begin
      if (m_keys_q[k] && !m_dropped[k]) begin
        held = 0;
        for (int v = 0; v < 4; v++) if (m_gate[v] && m_key[v] == k) held = 1;
        if (!held) req_q.push_back(k);
      end
    end
    m_note_on = '0;
    m_steal   = 0;
    m_pending = (req_q.size() > 1);
    if (req_q.size() > 0) begin
      v_sel = -1;
      for (int v = 0; v < 4; v++) if (!g_new[v] && v_sel < 0) v_sel = v;
      if (v_sel < 0) begin
        v_sel = lru_q[0];
        m_dropped[m_key[v_sel]] = 1;
        m_steal = 1;
      end
      m_key[v_sel] = req_q[0];
      g_new[v_sel] = 1;
      m_note_on[v_sel] = 1;
      for (int i = 0; i < lru_q.size(); i++)
        if (lru_q[i] == v_sel) begin lru_q.delete(i); break; end
      lru_q.push_back(v_sel);
    end
    m_gate   = g_new;
    m_keys_q = in_keys;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] pack4(input int k0, input int k1, input int k2, input int k3);
    logic [19:0] r;
    r = {5'(k3), 5'(k2), 5'(k1), 5'(k0)};
    return r;
  endfunction

  task automatic compare_model();
    check("model_gate", {28'd0, voice_gate}, {28'd0, m_gate});
    check("model_note_on", {28'd0, note_on}, {28'd0, m_note_on});
    check("model_steal", {31'd0, steal}, {31'd0, m_steal});
    check("model_pending", {31'd0, pending}, {31'd0, m_pending});
    check("model_vkey", {12'd0, voice_key}, {12'd0, pack4(m_key[0], m_key[1], m_key[2], m_key[3])});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(keys);
    #1;
    if (model_on) compare_model();
  endtask

  task automatic do_reset();
    keys = '0;
    rst  = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [31:0] keys;
    logic [3:0]  gate;
    logic [3:0]  note_on;
    logic        steal;
    logic        pending;
    logic [19:0] vkey;
  } vec_t;

  vec_t vecs [9];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int notes, steals;

    // Each vector: keys driven before the edge, outputs expected after it.
    vecs[0] = '{32'h1,   4'b0000, 4'b0000, 1'b0, 1'b0, 20'h0};
    vecs[1] = '{32'h1,   4'b0001, 4'b0001, 1'b0, 1'b0, 20'h0};
    vecs[2] = '{32'h1,   4'b0001, 4'b0000, 1'b0, 1'b0, 20'h0};
    vecs[3] = '{32'h0,   4'b0001, 4'b0000, 1'b0, 1'b0, 20'h0};
    vecs[4] = '{32'h288, 4'b0000, 4'b0000, 1'b0, 1'b0, 20'h0};
    vecs[5] = '{32'h288, 4'b0001, 4'b0001, 1'b0, 1'b1, 20'h00003};
    vecs[6] = '{32'h288, 4'b0011, 4'b0010, 1'b0, 1'b1, 20'h000E3};
    vecs[7] = '{32'h288, 4'b0111, 4'b0100, 1'b0, 1'b0, 20'h024E3};
    vecs[8] = '{32'h288, 4'b0111, 4'b0000, 1'b0, 1'b0, 20'h024E3};

    do_reset();
    check("reset_gate", {28'd0, voice_gate}, 32'd0);
    check("reset_note_on", {28'd0, note_on}, 32'd0);
    check("reset_steal_pending", {30'd0, steal, pending}, 32'd0);
    check("reset_vkey", {12'd0, voice_key}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      keys = vecs[i].keys;
      tick();
      check($sformatf("vec%0d_gate", i), {28'd0, voice_gate}, {28'd0, vecs[i].gate});
      check($sformatf("vec%0d_note_on", i), {28'd0, note_on}, {28'd0, vecs[i].note_on});
      check($sformatf("vec%0d_steal", i), {31'd0, steal}, {31'd0, vecs[i].steal});
      check($sformatf("vec%0d_pending", i), {31'd0, pending}, {31'd0, vecs[i].pending});
      check($sformatf("vec%0d_vkey", i), {12'd0, voice_key}, {12'd0, vecs[i].vkey});
    end

    // Voice stealing, dropped-key handling and release/press in one cycle.
    do_reset();
    keys = 32'h1E;
    repeat (5) tick();
    check("fill_gate", {28'd0, voice_gate}, 32'hF);
    check("fill_vkey", {12'd0, voice_key}, {12'd0, pack4(1, 2, 3, 4)});
    keys = 32'h3E;
    repeat (2) tick();
    check("steal1_flag", {31'd0, steal}, 32'd1);
    check("steal1_note_on", {28'd0, note_on}, 32'b0001);
    check("steal1_vkey", {12'd0, voice_key}, {12'd0, pack4(5, 2, 3, 4)});
    tick();
    check("steal1_pulse_end", {27'd0, steal, note_on}, 32'd0);
    keys = 32'h3C;
    repeat (2) tick();
    check("drop_release_note_on", {28'd0, note_on}, 32'd0);
    check("drop_release_vkey", {12'd0, voice_key}, {12'd0, pack4(5, 2, 3, 4)});
    check("drop_release_gate", {28'd0, voice_gate}, 32'hF);
    keys = 32'h3E;
    repeat (2) tick();
    check("steal2_flag", {31'd0, steal}, 32'd1);
    check("steal2_note_on", {28'd0, note_on}, 32'b0010);
    check("steal2_vkey", {12'd0, voice_key}, {12'd0, pack4(5, 1, 3, 4)});
    keys = 32'h76;
    repeat (2) tick();
    check("swap_steal", {31'd0, steal}, 32'd0);
    check("swap_note_on", {28'd0, note_on}, 32'b0100);
    check("swap_vkey", {12'd0, voice_key}, {12'd0, pack4(5, 1, 6, 4)});
    check("swap_gate", {28'd0, voice_gate}, 32'hF);

    // Every key pressed at once from idle.
    do_reset();
    keys = 32'hFFFF_FFFF;
    tick();
    notes = 0;
    steals = 0;
    for (int i = 0; i < 36; i++) begin
      tick();
      if (i == 0) check("all_pending_first", {31'd0, pending}, 32'd1);
      notes += $countones(note_on);
      steals += int'(steal);
    end
    check("all_notes", notes, 32);
    check("all_steals", steals, 28);
    check("all_vkey", {12'd0, voice_key}, {12'd0, pack4(28, 29, 30, 31)});
    check("all_gate", {28'd0, voice_gate}, 32'hF);
    check("all_pending_end", {31'd0, pending}, 32'd0);

    // Asynchronous reset while three voices sound.
    do_reset();
    keys = 32'h7;
    repeat (5) tick();
    check("pre_rst_gate", {28'd0, voice_gate}, 32'b0111);
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_gate", {28'd0, voice_gate}, 32'd0);
    check("async_rst_vkey", {12'd0, voice_key}, 32'd0);
    check("async_rst_flags", {26'd0, note_on, steal, pending}, 32'd0);
    #2;
    rst = 1'b0;
    tick();
    check("post_rst_gate0", {28'd0, voice_gate}, 32'd0);
    tick();
    check("post_rst_gate1", {28'd0, voice_gate}, 32'b0001);
    check("post_rst_note1", {28'd0, note_on}, 32'b0001);
    tick();
    check("post_rst_gate2", {28'd0, voice_gate}, 32'b0011);
    tick();
    check("post_rst_gate3", {28'd0, voice_gate}, 32'b0111);
    check("post_rst_vkey", {12'd0, voice_key}, {12'd0, pack4(0, 1, 2, 0)});

    // Random key traffic against the reference model.
    do_reset();
    model_on = 1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) keys[$urandom_range(0, 9)] ^= 1'b1;
      if ($urandom_range(0, 60) == 0) keys = $urandom();
      if ($urandom_range(0, 80) == 0) keys = '0;
      tick();
    end
    model_on = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
